// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default framing constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 868;
    localparam int UART_DATA_BITS            = 8;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while not cleared and flags the last cycle of each bit.
module uart_baud_cnt import uart_pkg::*; #(
    parameter  int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count,
    output logic             o_bit_tick
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    assign o_bit_tick = !i_clear && (r_count == LAST_CNT);
    assign o_count    = r_count;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (o_bit_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that pops bytes from a registered-output FIFO and sends them as 8N1/8N2 frames.
module uart_tx_fifo_drain import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_dout,
    output logic                 fifo_rd_en,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] LAST_DATA    = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP    = IDX_W'(STOP_BITS - 1);

    tx_state_t            r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [IDX_W-1:0]     r_bit_idx;
    logic                 r_tx;
    logic                 r_rd_en;
    logic                 r_busy;
    logic                 r_frame_done;

    logic                 w_baud_clear;
    logic                 w_bit_tick;
    logic [CNT_W-1:0]     w_baud_cnt;

    // The divider only runs while a bit is on the line, so it restarts from zero for every frame.
    assign w_baud_clear = !(r_state inside {START, DATA, STOP});

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_baud_clear),
        .o_count    (w_baud_cnt),
        .o_bit_tick (w_bit_tick)
    );

    assign fifo_rd_en = r_rd_en;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

    // Outputs are loaded on the same edge as the state they belong to, keeping them glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_tx         <= 1'b1;
            r_rd_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_rd_en      <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (enable && !fifo_empty) begin
                        r_state <= POP;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                POP: begin
                    r_state <= LOAD;
                end
                LOAD: begin
                    r_shift   <= fifo_dout;
                    r_bit_idx <= '0;
                    r_tx      <= 1'b0;
                    r_state   <= START;
                end
                START: begin
                    if (w_bit_tick) begin
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_tick) begin
                        r_shift <= r_shift >> 1;
                        if (r_bit_idx == LAST_DATA) begin
                            r_bit_idx <= '0;
                            r_tx      <= 1'b1;
                            r_state   <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                STOP: begin
                    // Raised one cycle early so the registered pulse lands on the final stop cycle.
                    if (r_bit_idx == LAST_STOP && w_baud_cnt == PRE_LAST_CNT) begin
                        r_frame_done <= 1'b1;
                    end
                    if (w_bit_tick) begin
                        if (r_bit_idx == LAST_STOP) begin
                            r_bit_idx <= '0;
                            r_busy    <= 1'b0;
                            r_state   <= IDLE;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
